// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_25040111_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW,
    ST_WR_B,
    ST_RESP
  } lsu_state_t;

  // Completion codes reported on resp_err
  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_BUS      = 2'b01;
  localparam logic [1:0] RESP_MISALIGN = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT  = 2'b11;

  // Access size encodings, bytes = 1 << size
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_END_DEF  = 32'h0200_ffff;

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational lane steering: write strobe, store data shift,
// load data extract/extend and misalignment detection.
module ysyx_25040111_lsu_align
  import ysyx_25040111_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size,
  input  logic [2:0]          addr_lo,
  input  logic                sign,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   wdata_sh,
  output logic [DATA_W-1:0]   rdata_ext,
  output logic                misaligned
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] strb_base;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              msb;

  assign off      = addr_lo[OFF_W-1:0];
  assign wdata_sh = wdata << {off, 3'b000};
  assign shifted  = rdata >> {off, 3'b000};
  assign strb     = strb_base << off;

  // Size-dependent strobe pattern, keep mask, sign bit and alignment check
  always_comb begin
    strb_base  = '1;
    mask       = '1;
    msb        = shifted[DATA_W-1];
    misaligned = 1'b0;
    case (size)
      SIZE_B: begin
        strb_base = STRB_W'(1);
        mask      = DATA_W'(8'hff);
        msb       = shifted[7];
      end
      SIZE_H: begin
        strb_base  = STRB_W'(3);
        mask       = DATA_W'(16'hffff);
        msb        = shifted[15];
        misaligned = addr_lo[0];
      end
      SIZE_W: begin
        strb_base  = STRB_W'(4'hf);
        mask       = DATA_W'(32'hffff_ffff);
        msb        = shifted[31];
        misaligned = (addr_lo[1:0] != 2'b00);
      end
      default: begin
        // doubleword only exists on a 64-bit bus
        misaligned = (DATA_W == 32) ? 1'b1 : (addr_lo != 3'b000);
      end
    endcase
  end

  assign rdata_ext = (sign & msb) ? (shifted | ~mask) : (shifted & mask);

endmodule

// File: rtl/ysyx_25040111_lsu_axi.sv
// Load/store unit: one access per request, single-beat AXI4 master
// or CLINT read port, with misalignment and timeout reporting.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | ready for a request
// ST_RD_A  | read address valid, waiting for arready
// ST_RD_D  | rready high, waiting for rvalid
// ST_WR_AW | aw/w valid, waiting for both handshakes
// ST_WR_B  | bready high, waiting for bvalid
// ST_RESP  | one-cycle resp_valid pulse
module ysyx_25040111_lsu_axi
  import ysyx_25040111_lsu_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] CLINT_BASE = ADDR_W'(CLINT_BASE_DEF),
  parameter logic [ADDR_W-1:0] CLINT_END  = ADDR_W'(CLINT_END_DEF),
  parameter int unsigned     TIMEOUT    = 1024,
  parameter logic [3:0]      AXI_ID     = 4'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic                req_sign,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [3:0]          m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                clint_arvalid,
  input  logic                clint_arready,
  output logic [ADDR_W-1:0]   clint_araddr,
  input  logic                clint_rvalid,
  output logic                clint_rready,
  input  logic [DATA_W-1:0]   clint_rdata,
  input  logic [1:0]          clint_rresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  lsu_state_t state, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              is_clint_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TW-1:0]     timer;
  logic              aw_done, w_done;

  logic              in_clint;
  logic              expire;
  logic              aw_hs, w_hs;
  logic              ar_ready_sel, r_valid_sel;
  logic [1:0]        r_resp_sel;
  logic [DATA_W-1:0] r_data_sel;
  logic [1:0]        err_d;
  logic [DATA_W-1:0] rdata_d;

  logic [1:0]        al_size;
  logic [2:0]        al_addr;
  logic              al_sign;
  logic [STRB_W-1:0] al_strb;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_mis;

  assign in_clint = (req_addr >= CLINT_BASE) && (req_addr <= CLINT_END);
  assign expire   = (TIMEOUT != 0) && (timer == T_LAST);

  // The aligner sees the live request while idle (misalign check, store
  // steering) and the latched request afterwards (load extraction).
  assign al_size = (state == ST_IDLE) ? req_size     : size_q;
  assign al_addr = (state == ST_IDLE) ? req_addr[2:0] : addr_q[2:0];
  assign al_sign = (state == ST_IDLE) ? req_sign     : sign_q;

  assign ar_ready_sel = is_clint_q ? clint_arready : m_arready;
  assign r_valid_sel  = is_clint_q ? clint_rvalid  : m_rvalid;
  assign r_resp_sel   = is_clint_q ? clint_rresp   : m_rresp;
  assign r_data_sel   = is_clint_q ? clint_rdata   : m_rdata;

  ysyx_25040111_lsu_align #(.DATA_W(DATA_W)) u_align (
    .size       (al_size),
    .addr_lo    (al_addr),
    .sign       (al_sign),
    .wdata      (req_wdata),
    .rdata      (r_data_sel),
    .strb       (al_strb),
    .wdata_sh   (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  assign m_awaddr     = addr_q;
  assign m_awid       = AXI_ID;
  assign m_awlen      = 8'd0;
  assign m_awsize     = {1'b0, size_q};
  assign m_awburst    = AXI_BURST_INCR;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = strb_q;
  assign m_wlast      = m_wvalid;
  assign m_araddr     = addr_q;
  assign m_arid       = AXI_ID;
  assign m_arlen      = 8'd0;
  assign m_arsize     = {1'b0, size_q};
  assign m_arburst    = AXI_BURST_INCR;
  assign clint_araddr = addr_q;

  // Next-state, channel valids/readies and the completion code
  always_comb begin
    state_d       = state;
    err_d         = RESP_OK;
    rdata_d       = '0;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    m_arvalid     = 1'b0;
    clint_arvalid = 1'b0;
    m_rready      = 1'b0;
    clint_rready  = 1'b0;
    m_awvalid     = 1'b0;
    m_wvalid      = 1'b0;
    m_bready      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (al_mis) begin
            state_d = ST_RESP;
            err_d   = RESP_MISALIGN;
          end else if (req_wen && in_clint) begin
            // CLINT is reachable through a read-only port only
            state_d = ST_RESP;
            err_d   = RESP_BUS;
          end else if (req_wen) begin
            state_d = ST_WR_AW;
          end else begin
            state_d = ST_RD_A;
          end
        end
      end
      ST_RD_A: begin
        m_arvalid     = ~is_clint_q;
        clint_arvalid = is_clint_q;
        if (ar_ready_sel) begin
          state_d = ST_RD_D;
        end else if (expire) begin
          state_d = ST_RESP;
          err_d   = RESP_TIMEOUT;
        end
      end
      ST_RD_D: begin
        m_rready     = ~is_clint_q;
        clint_rready = is_clint_q;
        if (r_valid_sel) begin
          state_d = ST_RESP;
          if (r_resp_sel != 2'b00) begin
            err_d = RESP_BUS;
          end else begin
            rdata_d = al_rdata;
          end
        end else if (expire) begin
          state_d = ST_RESP;
          err_d   = RESP_TIMEOUT;
        end
      end
      ST_WR_AW: begin
        m_awvalid = ~aw_done;
        m_wvalid  = ~w_done;
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_d = ST_WR_B;
        end else if (expire) begin
          state_d = ST_RESP;
          err_d   = RESP_TIMEOUT;
        end
      end
      ST_WR_B: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          state_d = ST_RESP;
          if (m_bresp != 2'b00) err_d = RESP_BUS;
        end else if (expire) begin
          state_d = ST_RESP;
          err_d   = RESP_TIMEOUT;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, request latch, watchdog timer and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      is_clint_q <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      timer      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_err   <= RESP_OK;
      resp_rdata <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && req_valid) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        sign_q     <= req_sign;
        is_clint_q <= in_clint;
        strb_q     <= al_strb;
        wdata_q    <= al_wdata;
      end
      if (state_d != state) begin
        timer <= '0;
      end else if (state != ST_IDLE && state != ST_RESP) begin
        timer <= timer + 1'b1;
      end
      if (state != ST_WR_AW) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state_d == ST_RESP && state != ST_RESP) begin
        resp_err   <= err_d;
        resp_rdata <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_lsu_axi.sv
// Directed bench for the load/store unit on a 32-bit bus, watchdog at 16.
module tb_ysyx_25040111_lsu_axi;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        clint_arvalid, clint_arready;
  logic [31:0] clint_araddr;
  logic        clint_rvalid, clint_rready;
  logic [31:0] clint_rdata;
  logic [1:0]  clint_rresp;

  int n_checks = 0;
  int n_errors = 0;

  int          r_cyc;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;
  logic        r_pulse_after, r_ready_after;
  logic        seen_mar, seen_car, seen_aw, seen_w;
  logic [31:0] s_araddr, s_wdata;
  logic [3:0]  s_wstrb;
  int          pulses;

  ysyx_25040111_lsu_axi #(
    .DATA_W(32), .ADDR_W(32), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_sign(req_sign), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .clint_arvalid(clint_arvalid), .clint_arready(clint_arready),
    .clint_araddr(clint_araddr),
    .clint_rvalid(clint_rvalid), .clint_rready(clint_rready),
    .clint_rdata(clint_rdata), .clint_rresp(clint_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (m_arvalid) begin
      seen_mar = 1'b1;
      s_araddr = m_araddr;
    end
    if (clint_arvalid) seen_car = 1'b1;
    if (m_awvalid) seen_aw = 1'b1;
    if (m_wvalid) begin
      seen_w  = 1'b1;
      s_wdata = m_wdata;
      s_wstrb = m_wstrb;
    end
  endtask

  // Issue one request and follow it to its response (bounded at 40 cycles).
  task automatic run_op(input logic wen, input logic sign, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_wen   = wen;
    req_sign  = sign;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    r_cyc    = 1;
    seen_mar = 1'b0;
    seen_car = 1'b0;
    seen_aw  = 1'b0;
    seen_w   = 1'b0;
    sample();
    while (!resp_valid && r_cyc < 40) begin
      tick();
      r_cyc++;
      sample();
    end
    r_rdata = resp_rdata;
    r_err   = resp_err;
    tick();
    r_pulse_after = resp_valid;
    r_ready_after = req_ready;
  endtask

  task automatic check_op(input string tag, input int exp_cyc,
                          input logic [1:0] exp_err, input logic [31:0] exp_rdata);
    check({tag, "_cycles"}, 32'(r_cyc), 32'(exp_cyc));
    check({tag, "_err"}, 32'(r_err), 32'(exp_err));
    check({tag, "_rdata"}, r_rdata, exp_rdata);
    check({tag, "_one_pulse"}, 32'(r_pulse_after), 32'd0);
    check({tag, "_idle_after"}, 32'(r_ready_after), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_sign = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0; m_rresp = 2'b00;
    clint_arready = 1'b1; clint_rvalid = 1'b1; clint_rdata = 32'h0; clint_rresp = 2'b00;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_valids", 32'({m_arvalid, m_awvalid, m_wvalid, clint_arvalid}), 32'd0);
    #2 rst = 1'b0;
    tick();

    // lw, zero-wait slave
    m_rdata = 32'hDEAD_BEEF;
    run_op(1'b0, 1'b0, 2'd2, 32'h8000_0004, 32'h0);
    check_op("lw", 3, 2'b00, 32'hDEAD_BEEF);
    check("lw_m_ar_used", 32'(seen_mar), 32'd1);
    check("lw_clint_idle", 32'(seen_car), 32'd0);
    check("lw_araddr", s_araddr, 32'h8000_0004);

    // byte loads from the top lane
    m_rdata = 32'h8012_3456;
    run_op(1'b0, 1'b1, 2'd0, 32'h8000_0003, 32'h0);
    check_op("lb", 3, 2'b00, 32'hFFFF_FF80);
    run_op(1'b0, 1'b0, 2'd0, 32'h8000_0003, 32'h0);
    check_op("lbu", 3, 2'b00, 32'h0000_0080);

    // halfword loads, both lanes
    m_rdata = 32'h8765_1234;
    run_op(1'b0, 1'b1, 2'd1, 32'h8000_0002, 32'h0);
    check_op("lh", 3, 2'b00, 32'hFFFF_8765);
    run_op(1'b0, 1'b0, 2'd1, 32'h8000_0000, 32'h0);
    check_op("lhu", 3, 2'b00, 32'h0000_1234);

    // stores, zero-wait slave
    run_op(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'hCAFE_BABE);
    check_op("sw", 3, 2'b00, 32'h0);
    check("sw_wstrb", 32'(s_wstrb), 32'hF);
    check("sw_wdata", s_wdata, 32'hCAFE_BABE);
    run_op(1'b1, 1'b0, 2'd0, 32'h8000_0001, 32'h0000_00A5);
    check_op("sb", 3, 2'b00, 32'h0);
    check("sb_wstrb", 32'(s_wstrb), 32'b0010);
    check("sb_wdata", s_wdata, 32'h0000_A500);

    // sh with awready arriving two cycles after the W handshake
    m_awready = 1'b0; m_wready = 1'b1;
    req_wen = 1'b1; req_sign = 1'b0; req_size = 2'd1;
    req_addr = 32'h8000_0002; req_wdata = 32'h0000_1234; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("sh_awvalid", 32'(m_awvalid), 32'd1);
    check("sh_wvalid", 32'(m_wvalid), 32'd1);
    check("sh_wlast", 32'(m_wlast), 32'd1);
    check("sh_wstrb", 32'(m_wstrb), 32'b1100);
    check("sh_wdata", m_wdata, 32'h1234_0000);
    check("sh_awsize", 32'(m_awsize), 32'd1);
    tick();
    m_wready = 1'b0;
    check("sh_w_dropped", 32'(m_wvalid), 32'd0);
    check("sh_aw_held", 32'(m_awvalid), 32'd1);
    tick();
    check("sh_aw_held2", 32'(m_awvalid), 32'd1);
    m_awready = 1'b1;
    tick();
    check("sh_aw_dropped", 32'(m_awvalid), 32'd0);
    check("sh_bready", 32'(m_bready), 32'd1);
    tick();
    check("sh_resp_valid", 32'(resp_valid), 32'd1);
    check("sh_resp_err", 32'(resp_err), 32'd0);
    tick();
    check("sh_one_pulse", 32'(resp_valid), 32'd0);
    m_wready = 1'b1;

    // bus errors on read and write responses
    m_rresp = 2'b10;
    run_op(1'b0, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
    check_op("lw_slverr", 3, 2'b01, 32'h0);
    m_rresp = 2'b00;
    m_bresp = 2'b11;
    run_op(1'b1, 1'b0, 2'd2, 32'h8000_0000, 32'h1111_1111);
    check_op("sw_decerr", 3, 2'b01, 32'h0);
    m_bresp = 2'b00;

    // misaligned accesses complete without touching the bus
    run_op(1'b0, 1'b0, 2'd2, 32'h8000_0002, 32'h0);
    check_op("lw_mis", 1, 2'b10, 32'h0);
    check("lw_mis_no_ar", 32'(seen_mar | seen_car), 32'd0);
    run_op(1'b0, 1'b1, 2'd1, 32'h8000_0001, 32'h0);
    check_op("lh_mis", 1, 2'b10, 32'h0);
    run_op(1'b1, 1'b0, 2'd3, 32'h8000_0000, 32'h0);
    check_op("sd_mis", 1, 2'b10, 32'h0);
    check("sd_mis_no_aw", 32'(seen_aw | seen_w), 32'd0);

    // CLINT routing
    clint_rdata = 32'h1122_3344;
    m_rdata     = 32'h5555_5555;
    run_op(1'b0, 1'b0, 2'd2, 32'h0200_bff8, 32'h0);
    check_op("clint_lw", 3, 2'b00, 32'h1122_3344);
    check("clint_lw_port", 32'({seen_car, seen_mar}), 32'b10);
    run_op(1'b1, 1'b0, 2'd2, 32'h0200_bff8, 32'h0);
    check_op("clint_sw", 1, 2'b01, 32'h0);
    check("clint_sw_no_aw", 32'(seen_aw | seen_w), 32'd0);

    // watchdog: arready never comes
    m_arready = 1'b0;
    run_op(1'b0, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
    check_op("timeout", 17, 2'b11, 32'h0);
    check("timeout_arvalid_low", 32'(m_arvalid), 32'd0);
    m_arready = 1'b1;

    // reset while waiting for read data
    m_rvalid = 1'b0;
    req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0008; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_mid_rready", 32'(m_rready), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_rready_low", 32'(m_rready), 32'd0);
    #1 rst = 1'b0;
    m_rvalid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid) pulses++;
    end
    check("rst_mid_no_resp", 32'(pulses), 32'd0);
    check("rst_mid_idle", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
